// File: rtl/pe_fanout_tx.sv
// Egress network interface: buffers PE packets in a small FIFO and replicates
// each one into FANOUT router flits with consecutive destinations, skipping SELF_ADDRESS.
module pe_fanout_tx #(
  parameter int PACKET_SIZE  = 32,
  parameter int DEST_WIDTH   = 4,
  parameter int FANOUT       = 4,
  parameter int DEST_BASE    = 0,
  parameter int SELF_ADDRESS = 1,
  parameter int DEPTH        = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            PE_NI_valid,
  input  logic [PACKET_SIZE-1:0]          PE_NI_packet,
  output logic                            PE_NI_ready,
  output logic                            NI_R_valid,
  output logic [DEST_WIDTH+PACKET_SIZE-1:0] NI_R_flit,
  input  logic                            NI_R_ready,
  output logic [15:0]                     flit_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (FANOUT > 1) ? $clog2(FANOUT) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SEND,
    ST_SKIP
  } state_t;

  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [IDX_W-1:0]       idx;
  logic [DEST_WIDTH-1:0]  dest;
  state_t                 state;
  logic                   push;
  logic                   advance;
  logic                   last_copy;
  logic                   pop;

  // Destination wraps naturally modulo 2^DEST_WIDTH.
  assign dest = DEST_WIDTH'(DEST_BASE) + DEST_WIDTH'(idx);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state = ST_EMPTY;
    if (count != '0) begin
      state = (dest == DEST_WIDTH'(SELF_ADDRESS)) ? ST_SKIP : ST_SEND;
    end
  end

  // All outputs are decoded from registered state only; no input-to-output path.
  assign PE_NI_ready = (count != CNT_W'(DEPTH));
  assign NI_R_valid  = (state == ST_SEND);
  assign NI_R_flit   = NI_R_valid ? {dest, mem[rd_ptr]} : '0;

  assign push      = PE_NI_valid && PE_NI_ready;
  assign advance   = (state == ST_SKIP) || ((state == ST_SEND) && NI_R_ready);
  assign last_copy = (idx == IDX_W'(FANOUT - 1));
  assign pop       = advance && last_copy;

  // NOTE: packet storage has no reset; the count gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= PE_NI_packet;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      flit_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (advance) begin
        idx <= last_copy ? '0 : idx + IDX_W'(1);
      end
      if (NI_R_valid && NI_R_ready) begin
        flit_count <= flit_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_fanout_tx.sv
// Self-checking bench for pe_fanout_tx: three instances with different fanout
// geometries share stimulus; table-driven vectors plus streamed corner cases.
module tb_pe_fanout_tx;

  localparam int PS    = 32;
  localparam int DW    = 4;
  localparam int FW    = DW + PS;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst;
  logic          pe_valid;
  logic [PS-1:0] pe_packet;
  logic          nr_ready;

  logic          v_o  [3];
  logic [FW-1:0] f_o  [3];
  logic          r_o  [3];
  logic [15:0]   fc_o [3];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 if (clk_en) clk = ~clk;

  // Instance 0: skip at copy 1 (base 0, self 1, fanout 4)
  pe_fanout_tx #(.PACKET_SIZE(PS), .DEST_WIDTH(DW), .FANOUT(4), .DEST_BASE(0),
                 .SELF_ADDRESS(1), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .PE_NI_valid(pe_valid), .PE_NI_packet(pe_packet),
    .PE_NI_ready(r_o[0]), .NI_R_valid(v_o[0]), .NI_R_flit(f_o[0]),
    .NI_R_ready(nr_ready), .flit_count(fc_o[0]));

  // Instance 1: destination wrap 14,15,0 (fanout 3)
  pe_fanout_tx #(.PACKET_SIZE(PS), .DEST_WIDTH(DW), .FANOUT(3), .DEST_BASE(14),
                 .SELF_ADDRESS(1), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .PE_NI_valid(pe_valid), .PE_NI_packet(pe_packet),
    .PE_NI_ready(r_o[1]), .NI_R_valid(v_o[1]), .NI_R_flit(f_o[1]),
    .NI_R_ready(nr_ready), .flit_count(fc_o[1]));

  // Instance 2: plain fanout 4,5,6,7
  pe_fanout_tx #(.PACKET_SIZE(PS), .DEST_WIDTH(DW), .FANOUT(4), .DEST_BASE(4),
                 .SELF_ADDRESS(1), .DEPTH(DEPTH)) u_c (
    .clk(clk), .rst(rst), .PE_NI_valid(pe_valid), .PE_NI_packet(pe_packet),
    .PE_NI_ready(r_o[2]), .NI_R_valid(v_o[2]), .NI_R_flit(f_o[2]),
    .NI_R_ready(nr_ready), .flit_count(fc_o[2]));

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [PS-1:0] p;
    logic [15:0]   fc;
  } exp_t;

  typedef struct packed {
    logic          pv;
    logic [PS-1:0] pkt;
    exp_t [2:0]    e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic v, input int d, input logic [PS-1:0] p, input int fc);
    exp_t r;
    r.v  = v;
    r.d  = DW'(d);
    r.p  = p;
    r.fc = 16'(fc);
    return r;
  endfunction

  function automatic vec_t row(input logic pv, input logic [PS-1:0] pkt,
                               input exp_t a, input exp_t b, input exp_t c);
    vec_t r;
    r.pv   = pv;
    r.pkt  = pkt;
    r.e[0] = a;
    r.e[1] = b;
    r.e[2] = c;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("%s_ready[%0d]", tag, j), 64'(r_o[j]), 64'd1);
      check($sformatf("%s_valid[%0d]", tag, j), 64'(v_o[j]), 64'd0);
      check($sformatf("%s_flit[%0d]", tag, j), 64'(f_o[j]), 64'd0);
      check($sformatf("%s_count[%0d]", tag, j), 64'(fc_o[j]), 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pe_valid  = 1'b0;
    pe_packet = '0;
    nr_ready  = 1'b0;
    rst       = 1'b1;
    #2;
    rst       = 1'b0;
  endtask

  // Pushes npk packets and drains them through instance inst, checking each
  // cycle against a small occupancy/sequence model (no self-address skip).
  task automatic run_stream(input int inst, input int fan, input int base, input int npk,
                            input bit rand_rr, input int rr_start);
    logic [PS-1:0] q [8];
    int pushed = 0;
    int k = 0;
    int mc = 0;
    int t = 0;
    logic exp_rdy;
    logic exp_v;
    logic [DW-1:0] d;
    for (int i = 0; i < 8; i++) q[i] = {16'hBEE0 ^ 16'(i), 16'(i * 37 + 1)};
    while (k < npk * fan && t < 300) begin
      @(negedge clk);
      pe_valid  = (pushed < npk);
      pe_packet = (pushed < npk) ? q[pushed] : '0;
      nr_ready  = rand_rr ? 1'($urandom_range(0, 1)) : (t >= rr_start);
      exp_rdy   = (mc != DEPTH);
      exp_v     = (mc > 0);
      check($sformatf("stream_ready[%0d]", inst), 64'(r_o[inst]), 64'(exp_rdy));
      check($sformatf("stream_valid[%0d]", inst), 64'(v_o[inst]), 64'(exp_v));
      if (exp_v) begin
        d = DW'(base + (k % fan));
        check($sformatf("stream_flit[%0d] k=%0d", inst, k), 64'(f_o[inst]), 64'({d, q[k / fan]}));
      end
      if (exp_v && nr_ready) begin
        if (k % fan == fan - 1) mc--;
        k++;
      end
      if (pe_valid && exp_rdy) begin
        mc++;
        pushed++;
      end
      t++;
    end
    check($sformatf("stream_done[%0d]", inst), 64'(k), 64'(npk * fan));
    @(negedge clk);
    pe_valid = 1'b0;
    check($sformatf("stream_end_valid[%0d]", inst), 64'(v_o[inst]), 64'd0);
    check($sformatf("stream_end_ready[%0d]", inst), 64'(r_o[inst]), 64'd1);
    check($sformatf("stream_end_count[%0d]", inst), 64'(fc_o[inst]), 64'(npk * fan));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    localparam logic [PS-1:0] P1 = 32'hA5A5_0001;
    localparam logic [PS-1:0] P2 = 32'h5A5A_0002;
    localparam logic [PS-1:0] X0 = 32'h1111_0000;
    localparam logic [PS-1:0] X1 = 32'h2222_0001;
    localparam logic [PS-1:0] X2 = 32'h3333_0002;
    vec_t tbl [10];

    // Two back-to-back packets, router always ready. Columns: inst0 (skip), inst1 (wrap), inst2 (plain)
    tbl[0] = row(1, P1, ex(0, 0, 0, 0),   ex(0, 0, 0, 0),   ex(0, 0, 0, 0));
    tbl[1] = row(1, P2, ex(1, 0, P1, 0),  ex(1, 14, P1, 0), ex(1, 4, P1, 0));
    tbl[2] = row(0, 0,  ex(0, 0, 0, 1),   ex(1, 15, P1, 1), ex(1, 5, P1, 1));
    tbl[3] = row(0, 0,  ex(1, 2, P1, 1),  ex(1, 0, P1, 2),  ex(1, 6, P1, 2));
    tbl[4] = row(0, 0,  ex(1, 3, P1, 2),  ex(1, 14, P2, 3), ex(1, 7, P1, 3));
    tbl[5] = row(0, 0,  ex(1, 0, P2, 3),  ex(1, 15, P2, 4), ex(1, 4, P2, 4));
    tbl[6] = row(0, 0,  ex(0, 0, 0, 4),   ex(1, 0, P2, 5),  ex(1, 5, P2, 5));
    tbl[7] = row(0, 0,  ex(1, 2, P2, 4),  ex(0, 0, 0, 6),   ex(1, 6, P2, 6));
    tbl[8] = row(0, 0,  ex(1, 3, P2, 5),  ex(0, 0, 0, 6),   ex(1, 7, P2, 7));
    tbl[9] = row(0, 0,  ex(0, 0, 0, 6),   ex(0, 0, 0, 6),   ex(0, 0, 0, 8));

    // Reset with the clock stopped
    pe_valid  = 1'b0;
    pe_packet = '0;
    nr_ready  = 1'b0;
    rst       = 1'b1;
    #2;
    check_reset("reset_noclk");
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Table-driven fanout, skip and wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pe_valid  = tbl[i].pv;
      pe_packet = tbl[i].pkt;
      nr_ready  = 1'b1;
      for (int j = 0; j < 3; j++) begin
        check($sformatf("tbl%0d_valid[%0d]", i, j), 64'(v_o[j]), 64'(tbl[i].e[j].v));
        check($sformatf("tbl%0d_flit[%0d]", i, j), 64'(f_o[j]),
              tbl[i].e[j].v ? 64'({tbl[i].e[j].d, tbl[i].e[j].p}) : 64'd0);
        check($sformatf("tbl%0d_ready[%0d]", i, j), 64'(r_o[j]), 64'd1);
        check($sformatf("tbl%0d_count[%0d]", i, j), 64'(fc_o[j]), 64'(tbl[i].e[j].fc));
      end
    end

    // Full FIFO: router stalled for 8 cycles while 5 packets are offered
    do_reset();
    run_stream(2, 4, 4, 5, 1'b0, 8);

    // Destination wrap with random router backpressure
    do_reset();
    run_stream(1, 3, 14, 3, 1'b1, 0);

    // Reset mid-fanout with packets still queued
    do_reset();
    @(negedge clk);
    pe_valid = 1'b1; pe_packet = X0; nr_ready = 1'b1;
    @(negedge clk);
    pe_packet = X1;
    @(negedge clk);
    pe_packet = X2;
    @(negedge clk);
    pe_valid = 1'b0;
    check("midrst_pre_flit", 64'(f_o[2]), 64'({4'd6, X0}));
    check("midrst_pre_count", 64'(fc_o[2]), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset("midrst_async");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("postrst%0d_valid[%0d]", c, j), 64'(v_o[j]), 64'd0);
        check($sformatf("postrst%0d_count[%0d]", c, j), 64'(fc_o[j]), 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
